// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizes rxd, deframes LSB-first bytes and holds each
// byte in a one-entry valid/ready output register with framing/overrun reporting.
module uart_rx_8n1 #(
    parameter int CLK_HZ = 125_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       valid,
    output logic [7:0] data,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

    // Fewer than four clocks per bit leaves no room for mid-bit sampling.
    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_8n1: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    (* ASYNC_REG = "TRUE" *) logic rxd_meta;
    (* ASYNC_REG = "TRUE" *) logic rxd_s;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          deliver;
    logic          stop_bad;

    // Two-flop synchronizer; resets to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Next-state logic: bit timer restarts on every state entry and after every sample.
    always_comb begin
        state_next   = state;
        count_next   = count + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        deliver      = 1'b0;
        stop_bad     = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (!rxd_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (count == HALF_LAST) begin
                    count_next = '0;
                    if (rxd_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (count == BIT_LAST) begin
                    count_next   = '0;
                    shift_next   = {rxd_s, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (count == BIT_LAST) begin
                    count_next = '0;
                    if (rxd_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                count_next = '0;
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // State register together with bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Output register: a delivery may reuse the slot in the same cycle it is handed off.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            data      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (deliver) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
